// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: multiply/divide opcode encoding and defaults.
package mips_pkg;

  localparam int unsigned MULDIV_OP_WIDTH      = 2;
  localparam int unsigned MULDIV_DEFAULT_WIDTH = 32;

  typedef enum logic [MULDIV_OP_WIDTH-1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } md_state_e;

endpackage

// File: rtl/mips_muldiv_signfix.sv
// Conditional two's-complement negation of a pair of words, either lane by lane
// or as one double-width value (joint_i) for full products.
module mips_muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] in_hi_i,
  input  logic [W-1:0] in_lo_i,
  input  logic         neg_hi_i,
  input  logic         neg_lo_i,
  input  logic         joint_i,
  output logic [W-1:0] out_hi_o,
  output logic [W-1:0] out_lo_o
);

  always_comb begin
    out_hi_o = in_hi_i;
    out_lo_o = in_lo_i;
    if (joint_i) begin
      // Joint mode uses neg_lo_i as the sign of the whole 2W value.
      if (neg_lo_i) {out_hi_o, out_lo_o} = -{in_hi_i, in_lo_i};
    end else begin
      if (neg_hi_i) out_hi_o = -in_hi_i;
      if (neg_lo_i) out_lo_o = -in_lo_i;
    end
  end

endmodule

// File: rtl/mips_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide,
// WIDTH iterations plus one sign-fix cycle; result held in hi/lo.
module mips_muldiv_seq
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MULDIV_OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]           operand_a,
  input  logic [WIDTH-1:0]           operand_b,
  input  logic                       flush,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           hi,
  output logic [WIDTH-1:0]           lo,
  output logic                       div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   a_q, a_d, opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d, done_q, done_d;

  muldiv_op_t       op_e;
  logic             signed_op, neg_a_in, neg_b_in;
  logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  assign op_e      = muldiv_op_t'(op);
  assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign neg_a_in  = signed_op && operand_a[WIDTH-1];
  assign neg_b_in  = signed_op && operand_b[WIDTH-1];

  // Magnitude of the most-negative value is exact when read as unsigned.
  mips_muldiv_signfix #(.W(WIDTH)) u_abs (
    .in_hi_i  (operand_a),
    .in_lo_i  (operand_b),
    .neg_hi_i (neg_a_in),
    .neg_lo_i (neg_b_in),
    .joint_i  (1'b0),
    .out_hi_o (mag_a),
    .out_lo_o (mag_b)
  );

  mips_muldiv_signfix #(.W(WIDTH)) u_fix (
    .in_hi_i  (is_div_q ? rem_q : acc_q[2*WIDTH-1:WIDTH]),
    .in_lo_i  (acc_q[WIDTH-1:0]),
    .neg_hi_i (is_div_q ? neg_a_q : (neg_a_q ^ neg_b_q)),
    .neg_lo_i (neg_a_q ^ neg_b_q),
    .joint_i  (!is_div_q),
    .out_hi_o (fix_hi),
    .out_lo_o (fix_lo)
  );

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          state_d  = StCalc;
          cnt_d    = '0;
          is_div_d = (op_e == MD_DIV) || (op_e == MD_DIVU);
          neg_a_d  = neg_a_in;
          neg_b_d  = neg_b_in;
          a_d      = operand_a;
          // Low half holds the multiplier or the dividend being shifted out.
          opnd_d   = mag_b;
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          rem_d    = '0;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              rem_d = div_diff[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = div_shift[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIter) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          dbz_d  = is_div_q && (opnd_q == '0);
          hi_d   = dbz_d ? a_q : fix_hi;
          lo_d   = dbz_d ? '1 : fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
